// File: rtl/vip_ycbcr444_rgb888.sv
// Full-range YCbCr444 to RGB888 converter: multiply, sum with offsets, clamp.
// Latency 3 clocks; free-running pipeline with no backpressure, one pixel per clock.
module vip_ycbcr444_rgb888 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_Y,
    input  logic [7:0] per_img_Cb,
    input  logic [7:0] per_img_Cr,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_red,
    output logic [7:0] post_img_green,
    output logic [7:0] post_img_blue
);

    logic [16:0] y256_d, cr359_d, cb88_d, cr183_d, cb454_d;
    logic [16:0] y256_q, cr359_q, cb88_q, cr183_q, cb454_q;

    logic signed [19:0] r_full_d, g_full_d, b_full_d;
    logic signed [19:0] r_full_q, g_full_q, b_full_q;

    logic [7:0] red_d, green_d, blue_d;
    logic [7:0] red_q, green_q, blue_q;

    logic [2:0] vsync_d, href_d, clken_d;
    logic [2:0] vsync_q, href_q, clken_q;

    // Negative saturates to 0, anything at or above 256.0 saturates to 255.
    function automatic logic [7:0] clamp8(input logic signed [19:0] v);
        logic [7:0] res;
        if (v[19]) begin
            res = 8'd0;
        end else if (v[18:16] != 3'd0) begin
            res = 8'd255;
        end else begin
            res = v[15:8];
        end
        return res;
    endfunction

    always_comb begin
        y256_d  = {1'b0, per_img_Y, 8'd0};
        cr359_d = 17'(per_img_Cr) * 17'd359;
        cb88_d  = 17'(per_img_Cb) * 17'd88;
        cr183_d = 17'(per_img_Cr) * 17'd183;
        cb454_d = 17'(per_img_Cb) * 17'd454;
    end

    always_comb begin
        r_full_d = $signed({3'b000, y256_q}) + $signed({3'b000, cr359_q}) - 20'sd45952;
        g_full_d = $signed({3'b000, y256_q}) - $signed({3'b000, cb88_q})
                 - $signed({3'b000, cr183_q}) + 20'sd34688;
        b_full_d = $signed({3'b000, y256_q}) + $signed({3'b000, cb454_q}) - 20'sd58112;
    end

    always_comb begin
        red_d   = clamp8(r_full_q);
        green_d = clamp8(g_full_q);
        blue_d  = clamp8(b_full_q);
    end

    always_comb begin
        vsync_d = {vsync_q[1:0], per_frame_vsync};
        href_d  = {href_q[1:0],  per_frame_href};
        clken_d = {clken_q[1:0], per_frame_clken};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y256_q   <= '0;
            cr359_q  <= '0;
            cb88_q   <= '0;
            cr183_q  <= '0;
            cb454_q  <= '0;
            r_full_q <= '0;
            g_full_q <= '0;
            b_full_q <= '0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            vsync_q  <= '0;
            href_q   <= '0;
            clken_q  <= '0;
        end else begin
            y256_q   <= y256_d;
            cr359_q  <= cr359_d;
            cb88_q   <= cb88_d;
            cr183_q  <= cr183_d;
            cb454_q  <= cb454_d;
            r_full_q <= r_full_d;
            g_full_q <= g_full_d;
            b_full_q <= b_full_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            vsync_q  <= vsync_d;
            href_q   <= href_d;
            clken_q  <= clken_d;
        end
    end

    // Blank the pixel bus outside active line time.
    assign post_frame_vsync = vsync_q[2];
    assign post_frame_href  = href_q[2];
    assign post_frame_clken = clken_q[2];
    assign post_img_red     = href_q[2] ? red_q   : 8'd0;
    assign post_img_green   = href_q[2] ? green_q : 8'd0;
    assign post_img_blue    = href_q[2] ? blue_q  : 8'd0;

endmodule

// File: tb/tb_vip_ycbcr444_rgb888.sv
// Directed bench for the YCbCr444 to RGB888 converter.
module tb_vip_ycbcr444_rgb888;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       per_frame_vsync = 1'b0;
    logic       per_frame_href = 1'b0;
    logic       per_frame_clken = 1'b0;
    logic [7:0] per_img_Y = 8'd0;
    logic [7:0] per_img_Cb = 8'd0;
    logic [7:0] per_img_Cr = 8'd0;
    logic       post_frame_vsync, post_frame_href, post_frame_clken;
    logic [7:0] post_img_red, post_img_green, post_img_blue;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] vy[8], vcb[8], vcr[8], er[8], eg[8], eb[8];
    logic [26:0] obs;
    assign obs = {post_frame_vsync, post_frame_href, post_frame_clken,
                  post_img_red, post_img_green, post_img_blue};

    vip_ycbcr444_rgb888 dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_Y        (per_img_Y),
        .per_img_Cb       (per_img_Cb),
        .per_img_Cr       (per_img_Cr),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_red     (post_img_red),
        .post_img_green   (post_img_green),
        .post_img_blue    (post_img_blue)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic h, input logic c,
                         input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        per_frame_vsync = v;
        per_frame_href  = h;
        per_frame_clken = c;
        per_img_Y       = y;
        per_img_Cb      = cb;
        per_img_Cr      = cr;
    endtask

    // Hand-computed vectors: {Y, Cb, Cr} -> {R, G, B}.
    task automatic load_vectors();
        vy[0] = 8'd128; vcb[0] = 8'd128; vcr[0] = 8'd128; er[0] = 8'd128; eg[0] = 8'd128; eb[0] = 8'd128;
        vy[1] = 8'd255; vcb[1] = 8'd128; vcr[1] = 8'd255; er[1] = 8'd255; eg[1] = 8'd164; eb[1] = 8'd255;
        vy[2] = 8'd0;   vcb[2] = 8'd0;   vcr[2] = 8'd0;   er[2] = 8'd0;   eg[2] = 8'd135; eb[2] = 8'd0;
        vy[3] = 8'd76;  vcb[3] = 8'd85;  vcr[3] = 8'd255; er[3] = 8'd254; eg[3] = 8'd0;   eb[3] = 8'd0;
        vy[4] = 8'd100; vcb[4] = 8'd150; vcr[4] = 8'd200; er[4] = 8'd200; eg[4] = 8'd40;  eb[4] = 8'd139;
        vy[5] = 8'd200; vcb[5] = 8'd60;  vcr[5] = 8'd90;  er[5] = 8'd146; eg[5] = 8'd250; eb[5] = 8'd79;
        vy[6] = 8'd255; vcb[6] = 8'd128; vcr[6] = 8'd128; er[6] = 8'd255; eg[6] = 8'd255; eb[6] = 8'd255;
        vy[7] = 8'd0;   vcb[7] = 8'd128; vcr[7] = 8'd128; er[7] = 8'd0;   eg[7] = 8'd0;   eb[7] = 8'd0;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 8'd200, 8'd60, 8'd90);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs !== 27'd0) begin
                n_fail++;
                $display("FAIL reset_held cyc=%0d got %h expected %h", i, obs, 27'd0);
            end
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1, vy[0], vcb[0], vcr[0]);
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++;
            if (i < 3 && obs !== 27'd0) begin
                n_fail++;
                $display("FAIL reset_release cyc=%0d got %h expected %h", i, obs, 27'd0);
            end else if (i == 3 && obs !== {3'b111, 8'd128, 8'd128, 8'd128}) begin
                n_fail++;
                $display("FAIL first_pixel_latency got %h expected %h", obs, {3'b111, 8'd128, 8'd128, 8'd128});
            end
        end
    endtask

    task automatic test_vectors();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b1, vy[i], vcb[i], vcr[i]);
            repeat (3) step();
            n_checks++;
            if (obs !== {3'b011, er[i], eg[i], eb[i]}) begin
                n_fail++;
                $display("FAIL vector_%0d got %h expected %h", i, obs, {3'b011, er[i], eg[i], eb[i]});
            end
        end
    endtask

    task automatic test_burst();
        logic hv[12], hh[12], hc[12];
        logic [26:0] exp_o;
        for (int c = 0; c < 12; c++) begin
            hv[c] = (c == 0);
            hh[c] = (c < 6);
            hc[c] = (c % 3 != 2);
            if (c < 6) drive(hv[c], hh[c], hc[c], vy[c], vcb[c], vcr[c]);
            else       drive(hv[c], hh[c], hc[c], 8'd200, 8'd60, 8'd90);
            step();
            if (c >= 2) begin
                exp_o = {hv[c-2], hh[c-2], hc[c-2],
                         (c - 2 < 6) ? {er[c-2], eg[c-2], eb[c-2]} : 24'd0};
                n_checks++;
                if (obs !== exp_o) begin
                    n_fail++;
                    $display("FAIL burst k=%0d got %h expected %h", c - 2, obs, exp_o);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic hh[12];
        logic [26:0] exp_o;
        for (int c = 0; c < 12; c++) begin
            hh[c] = (c < 10) && (c % 2 == 0);
            drive(1'b0, hh[c], 1'b1, vy[c % 8], vcb[c % 8], vcr[c % 8]);
            step();
            if (c >= 2) begin
                exp_o = {1'b0, hh[c-2], 1'b1,
                         hh[c-2] ? {er[(c-2) % 8], eg[(c-2) % 8], eb[(c-2) % 8]} : 24'd0};
                n_checks++;
                if (obs !== exp_o) begin
                    n_fail++;
                    $display("FAIL back_to_back k=%0d got %h expected %h", c - 2, obs, exp_o);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 1'b1, vy[1], vcb[1], vcr[1]);
        repeat (3) step();
        n_checks++;
        if (obs !== {3'b111, er[1], eg[1], eb[1]}) begin
            n_fail++;
            $display("FAIL pre_reset got %h expected %h", obs, {3'b111, er[1], eg[1], eb[1]});
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 27'd0) begin
            n_fail++;
            $display("FAIL async_assert got %h expected %h", obs, 27'd0);
        end
        drive(1'b0, 1'b0, 1'b0, vy[5], vcb[5], vcr[5]);
        step();
        n_checks++;
        if (obs !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_hold got %h expected %h", obs, 27'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (obs !== 27'd0) begin
                n_fail++;
                $display("FAIL post_release cyc=%0d got %h expected %h", i, obs, 27'd0);
            end
        end
    endtask

    initial begin
        load_vectors();
        test_reset();
        test_vectors();
        test_burst();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
